// File: rtl/ttpu_pkg.sv
// Shared definitions for the systolic-array sequencer: lane geometry,
// sequencer states and the operand-length range check.
package ttpu_pkg;

    localparam int LANES         = 32;
    localparam int DW            = 16;
    localparam int MAX_N         = 32;
    localparam int TIMEOUT_SLACK = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        CLR,
        RUN,
        DRAIN,
        DONE
    } seq_state_t;

    function automatic logic n_in_range(input logic [5:0] n);
        return (n != 6'd0) && (n <= 6'(MAX_N));
    endfunction

endpackage

// File: rtl/systolic_sequencer_operand_fetch.sv
// Operand fetch: issues N sequential buffer reads from a base address and
// captures the 1-cycle-late read data into lane vector A or B (sel_b).
module operand_fetch #(
    parameter int LANES = ttpu_pkg::LANES,
    parameter int DW    = ttpu_pkg::DW,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          go,
    input  logic          sel_b,
    input  logic [5:0]    n,
    input  logic [AW-1:0] base,
    output logic          mem_rd_en,
    output logic [AW-1:0] mem_rd_addr,
    input  logic [DW-1:0] mem_rd_data,
    output logic          last,
    output logic [DW-1:0] vec_a [0:LANES-1],
    output logic [DW-1:0] vec_b [0:LANES-1]
);

    localparam int IW = $clog2(LANES);

    logic [IW-1:0] rd_idx;
    logic [IW-1:0] cap_idx;
    logic          cap_valid;
    logic          sel_q;
    logic [5:0]    n_q;

    // Data for a read arrives one cycle later, so the lane index rides along with it.
    assign last = cap_valid && (6'(cap_idx) == n_q - 6'd1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_rd_en   <= 1'b0;
            mem_rd_addr <= '0;
            rd_idx      <= '0;
            cap_idx     <= '0;
            cap_valid   <= 1'b0;
            sel_q       <= 1'b0;
            n_q         <= '0;
            for (int i = 0; i < LANES; i++) begin
                vec_a[i] <= '0;
                vec_b[i] <= '0;
            end
        end else begin
            cap_valid <= mem_rd_en;
            cap_idx   <= rd_idx;

            if (go) begin
                mem_rd_en   <= 1'b1;
                mem_rd_addr <= base;
                rd_idx      <= '0;
                n_q         <= n;
                sel_q       <= sel_b;
            end else if (mem_rd_en) begin
                if (6'(rd_idx) == n_q - 6'd1) begin
                    mem_rd_en <= 1'b0;
                end else begin
                    rd_idx      <= rd_idx + IW'(1);
                    mem_rd_addr <= mem_rd_addr + AW'(1);
                end
            end

            if (clear) begin
                for (int i = 0; i < LANES; i++) begin
                    vec_a[i] <= '0;
                    vec_b[i] <= '0;
                end
            end else if (cap_valid) begin
                if (sel_q) begin
                    vec_b[cap_idx] <= mem_rd_data;
                end else begin
                    vec_a[cap_idx] <= mem_rd_data;
                end
            end
        end
    end

endmodule

// File: rtl/systolic_sequencer.sv
// Sequencer for one systolic-array operation: load A/B, clear, run, drain results.
// Define SEQ_PERF_CNT_EN to add the perf_cycles accept-to-done cycle counter.
module systolic_sequencer
    import ttpu_pkg::*;
#(
    parameter int LANES = ttpu_pkg::LANES,
    parameter int DW    = ttpu_pkg::DW,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [5:0]    matrix_n,
    input  logic [AW-1:0] base_a,
    input  logic [AW-1:0] base_b,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          mem_rd_en,
    output logic [AW-1:0] mem_rd_addr,
    input  logic [DW-1:0] mem_rd_data,
    output logic          arr_clr,
    output logic          arr_en,
    output logic [5:0]    arr_n,
    output logic [DW-1:0] arr_a [0:LANES-1],
    output logic [DW-1:0] arr_b [0:LANES-1],
    input  logic [DW-1:0] arr_p [0:LANES-1],
    input  logic          arr_ready,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [DW-1:0] res_data,
    output logic [4:0]    res_idx
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [15:0]   perf_cycles
`endif
);

    seq_state_t    state;
    logic [AW-1:0] base_b_q;
    logic [6:0]    run_cnt;
    logic [6:0]    run_limit;
    logic          accept;
    logic          fetch_go;
    logic          fetch_last;
    logic [5:0]    fetch_n;
    logic [AW-1:0] fetch_base;

    assign accept     = (state == IDLE) && start && n_in_range(matrix_n);
    assign fetch_go   = accept || ((state == LOAD_A) && fetch_last);
    assign fetch_n    = (state == IDLE) ? matrix_n : arr_n;
    assign fetch_base = (state == IDLE) ? base_a : base_b_q;
    assign run_limit  = {arr_n, 1'b0} + 7'(TIMEOUT_SLACK);
    assign res_data   = res_valid ? arr_p[res_idx] : '0;

    operand_fetch #(
        .LANES (LANES),
        .DW    (DW),
        .AW    (AW)
    ) u_fetch (
        .clk         (clk),
        .reset       (reset),
        .clear       (accept),
        .go          (fetch_go),
        .sel_b       (state == LOAD_A),
        .n           (fetch_n),
        .base        (fetch_base),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .last        (fetch_last),
        .vec_a       (arr_a),
        .vec_b       (arr_b)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            arr_clr   <= 1'b0;
            arr_en    <= 1'b0;
            arr_n     <= '0;
            base_b_q  <= '0;
            run_cnt   <= '0;
            res_valid <= 1'b0;
            res_idx   <= '0;
        end else begin
            done    <= 1'b0;
            err     <= 1'b0;
            arr_clr <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (n_in_range(matrix_n)) begin
                            arr_n    <= matrix_n;
                            base_b_q <= base_b;
                            busy     <= 1'b1;
                            state    <= LOAD_A;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                LOAD_A: begin
                    if (fetch_last) state <= LOAD_B;
                end
                LOAD_B: begin
                    if (fetch_last) begin
                        arr_clr <= 1'b1;
                        state   <= CLR;
                    end
                end
                CLR: begin
                    arr_en  <= 1'b1;
                    run_cnt <= '0;
                    state   <= RUN;
                end
                // The array gets 2N+8 cycles to finish before the run is abandoned.
                RUN: begin
                    if (arr_ready) begin
                        arr_en    <= 1'b0;
                        res_valid <= 1'b1;
                        res_idx   <= '0;
                        state     <= DRAIN;
                    end else if (run_cnt == run_limit - 7'd1) begin
                        arr_en <= 1'b0;
                        err    <= 1'b1;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        run_cnt <= run_cnt + 7'd1;
                    end
                end
                DRAIN: begin
                    if (res_valid && res_ready) begin
                        if ({1'b0, res_idx} == arr_n - 6'd1) begin
                            res_valid <= 1'b0;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            state     <= DONE;
                        end else begin
                            res_idx <= res_idx + 5'd1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef SEQ_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_cycles <= '0;
        end else if (accept) begin
            perf_cycles <= '0;
        end else if (busy && (perf_cycles != 16'hFFFF)) begin
            perf_cycles <= perf_cycles + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_systolic_sequencer.sv
// Bench for systolic_sequencer: operand-buffer and array models, a per-cycle
// read/result checker, and directed operations with literal pins.
module tb_systolic_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [5:0]  matrix_n;
    logic [9:0]  base_a;
    logic [9:0]  base_b;
    logic        busy;
    logic        done;
    logic        err;
    logic        mem_rd_en;
    logic [9:0]  mem_rd_addr;
    logic [15:0] mem_rd_data;
    logic        arr_clr;
    logic        arr_en;
    logic [5:0]  arr_n;
    logic [15:0] arr_a [0:31];
    logic [15:0] arr_b [0:31];
    logic [15:0] arr_p [0:31];
    logic        arr_ready;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic [4:0]  res_idx;
`ifdef SEQ_PERF_CNT_EN
    logic [15:0] perf_cycles;
`endif

    logic [15:0] mem [0:1023];
    logic [9:0]  exp_addr [$];
    int          ready_delay = 0;
    int          en_cycles = 0;
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    int          done_cnt = 0;
    int          err_cnt = 0;
    int          clr_cnt = 0;
    int          res_total = 0;
    int          res_start = 0;
    int          run_cyc = 0;
    int          err_cyc = 0;
    bit          have_prev = 0;
    logic        prev_valid, prev_ready, prev_en;
    logic [4:0]  prev_idx;
    logic [15:0] prev_data;

    systolic_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .matrix_n    (matrix_n),
        .base_a      (base_a),
        .base_b      (base_b),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .arr_clr     (arr_clr),
        .arr_en      (arr_en),
        .arr_n       (arr_n),
        .arr_a       (arr_a),
        .arr_b       (arr_b),
        .arr_p       (arr_p),
        .arr_ready   (arr_ready),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_idx     (res_idx)
`ifdef SEQ_PERF_CNT_EN
        ,
        .perf_cycles (perf_cycles)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Operand buffer with one cycle of read latency; garbage when not read.
    always @(posedge clk) mem_rd_data <= mem_rd_en ? mem[mem_rd_addr] : 16'hBAD0;

    // Array finishes ready_delay enabled cycles after its clear; negative means never.
    always @(posedge clk) begin
        if (arr_clr) en_cycles <= 0;
        else if (arr_en) en_cycles <= en_cycles + 1;
    end
    assign arr_ready = arr_en && (ready_delay >= 0) && (en_cycles >= ready_delay);

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        int ridx;
        if (!reset) begin
            have_prev = 0;
        end else begin
            if (mem_rd_en) begin
                if (exp_addr.size() == 0) checkOutput("rd_en_without_pending_read", 32'(mem_rd_en), 32'd0);
                else checkOutput("rd_addr", 32'(mem_rd_addr), 32'(exp_addr.pop_front()));
            end
            if (res_valid && res_ready) begin
                ridx = res_total - res_start;
                if (ridx > 31) begin
                    checkOutput("extra_result", 32'(res_valid), 32'd0);
                end else begin
                    checkOutput("res_idx", 32'(res_idx), 32'(ridx));
                    checkOutput("res_data", 32'(res_data), 32'(arr_p[ridx[4:0]]));
                end
                res_total++;
            end
            if (have_prev && prev_valid && !prev_ready) begin
                checkOutput("stall_valid_hold", 32'(res_valid), 32'd1);
                checkOutput("stall_idx_hold", 32'(res_idx), 32'(prev_idx));
                checkOutput("stall_data_hold", 32'(res_data), 32'(prev_data));
            end
            if (done) done_cnt++;
            if (err) begin
                err_cnt++;
                err_cyc = cyc;
            end
            if (arr_clr) clr_cnt++;
            if (arr_en && !(have_prev && prev_en)) run_cyc = cyc;
            prev_valid = res_valid;
            prev_ready = res_ready;
            prev_en    = arr_en;
            prev_idx   = res_idx;
            prev_data  = res_data;
            have_prev  = 1;
        end
    end

    int last_busy_cycles;

    task automatic applyStimulus(input int n, input logic [9:0] ba, input logic [9:0] bb,
                                 input int delay, input bit toggle, input bit expect_ok);
        int d0, e0, c0, bc, cycles;
        bit fin;
        logic [15:0] lane_exp;
        for (int k = 0; k < n; k++) exp_addr.push_back(ba + 10'(k));
        for (int k = 0; k < n; k++) exp_addr.push_back(bb + 10'(k));
        for (int i = 0; i < 32; i++) arr_p[i] = 16'(n * 101 + i * 13 + 5);
        ready_delay = delay;
        res_ready   = 1'b1;
        d0 = done_cnt;
        e0 = err_cnt;
        c0 = clr_cnt;
        res_start = res_total;
        @(posedge clk);
        #1;
        matrix_n = 6'(n);
        base_a   = ba;
        base_b   = bb;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        fin = 0;
        cycles = 0;
        bc = 0;
        while (!fin && cycles < 400) begin
            @(negedge clk);
            cycles++;
            if (busy) bc++;
            if (done || err) begin
                fin = 1;
            end else begin
                @(posedge clk);
                #1;
                if (toggle) res_ready = !res_ready;
            end
        end
        last_busy_cycles = bc;
        res_ready = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("op_terminated", 32'(fin), 32'd1);
        checkOutput("busy_after", 32'(busy), 32'd0);
        checkOutput("arr_en_after", 32'(arr_en), 32'd0);
        checkOutput("res_valid_after", 32'(res_valid), 32'd0);
        checkOutput("arr_n_latched", 32'(arr_n), 32'(n));
        checkOutput("reads_outstanding", 32'(exp_addr.size()), 32'd0);
        if (expect_ok) begin
            checkOutput("done_count", 32'(done_cnt - d0), 32'd1);
            checkOutput("err_count", 32'(err_cnt - e0), 32'd0);
            checkOutput("clr_count", 32'(clr_cnt - c0), 32'd1);
            checkOutput("result_count", 32'(res_total - res_start), 32'(n));
            for (int i = 0; i < 32; i++) begin
                lane_exp = (i < n) ? mem[ba + 10'(i)] : 16'h0000;
                checkOutput($sformatf("arr_a[%0d]", i), 32'(arr_a[i]), 32'(lane_exp));
                lane_exp = (i < n) ? mem[bb + 10'(i)] : 16'h0000;
                checkOutput($sformatf("arr_b[%0d]", i), 32'(arr_b[i]), 32'(lane_exp));
            end
            if (!toggle) checkOutput("accept_to_done_cycles", 32'(bc), 32'(3 * n + delay + 4));
        end else begin
            checkOutput("done_count", 32'(done_cnt - d0), 32'd0);
            checkOutput("err_count", 32'(err_cnt - e0), 32'd1);
            checkOutput("result_count", 32'(res_total - res_start), 32'd0);
            checkOutput("timeout_distance", 32'(err_cyc - run_cyc), 32'(2 * n + 8));
        end
`ifdef SEQ_PERF_CNT_EN
        checkOutput("perf_cycles", 32'(perf_cycles), 32'(bc));
`endif
    endtask

    initial begin
        int d0, e0;
        reset     = 1'b0;
        start     = 1'b0;
        matrix_n  = '0;
        base_a    = '0;
        base_b    = '0;
        res_ready = 1'b1;
        for (int i = 0; i < 32; i++) arr_p[i] = 16'h0;
        for (int i = 0; i < 1024; i++) mem[i] = 16'(i * 7 + 256);
        for (int i = 0; i < 4; i++) begin
            mem[10'h010 + 10'(i)] = 16'(i + 1);
            mem[10'h020 + 10'(i)] = 16'(i + 5);
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_err", 32'(err), 32'd0);
        checkOutput("reset_rd_en", 32'(mem_rd_en), 32'd0);
        checkOutput("reset_rd_addr", 32'(mem_rd_addr), 32'd0);
        checkOutput("reset_clr", 32'(arr_clr), 32'd0);
        checkOutput("reset_en", 32'(arr_en), 32'd0);
        checkOutput("reset_arr_n", 32'(arr_n), 32'd0);
        checkOutput("reset_res_valid", 32'(res_valid), 32'd0);
        checkOutput("reset_res_idx", 32'(res_idx), 32'd0);
        checkOutput("reset_res_data", 32'(res_data), 32'd0);
        checkOutput("reset_arr_a0", 32'(arr_a[0]), 32'd0);
        checkOutput("reset_arr_b31", 32'(arr_b[31]), 32'd0);
`ifdef SEQ_PERF_CNT_EN
        checkOutput("reset_perf", 32'(perf_cycles), 32'd0);
`endif
        @(posedge clk);
        #1;
        reset = 1'b1;

        $display("[TB] basic N=4 run");
        applyStimulus(4, 10'h010, 10'h020, 2, 1'b0, 1'b1);
        checkOutput("pin_arr_a0", 32'(arr_a[0]), 32'd1);
        checkOutput("pin_arr_a3", 32'(arr_a[3]), 32'd4);
        checkOutput("pin_arr_b0", 32'(arr_b[0]), 32'd5);
        checkOutput("pin_arr_b3", 32'(arr_b[3]), 32'd8);
        checkOutput("pin_arr_a4", 32'(arr_a[4]), 32'd0);
        checkOutput("pin_cycles_n4", 32'(last_busy_cycles), 32'd18);

        $display("[TB] invalid N");
        d0 = done_cnt;
        e0 = err_cnt;
        @(posedge clk);
        #1;
        matrix_n = 6'd0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        checkOutput("err_n0", 32'(err), 32'd1);
        checkOutput("busy_n0", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        matrix_n = 6'd33;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        checkOutput("err_n33", 32'(err), 32'd1);
        checkOutput("busy_n33", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        checkOutput("err_pulse_width", 32'(err), 32'd0);
        checkOutput("busy_idle", 32'(busy), 32'd0);
        checkOutput("invalid_err_count", 32'(err_cnt - e0), 32'd2);
        checkOutput("invalid_done_count", 32'(done_cnt - d0), 32'd0);

        $display("[TB] N=32 with toggling res_ready");
        applyStimulus(32, 10'h100, 10'h200, 0, 1'b1, 1'b1);

        $display("[TB] reset during LOAD_B");
        d0 = done_cnt;
        for (int k = 0; k < 6; k++) exp_addr.push_back(10'h040 + 10'(k));
        for (int k = 0; k < 6; k++) exp_addr.push_back(10'h080 + 10'(k));
        @(posedge clk);
        #1;
        matrix_n = 6'd6;
        base_a = 10'h040;
        base_b = 10'h080;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_addr.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_rd_en", 32'(mem_rd_en), 32'd0);
        checkOutput("abort_arr_a0", 32'(arr_a[0]), 32'd0);
        checkOutput("abort_arr_n", 32'(arr_n), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("abort_no_done", 32'(done_cnt - d0), 32'd0);
        applyStimulus(2, 10'h0C0, 10'h0D0, 3, 1'b0, 1'b1);

        $display("[TB] array never ready, N=3");
        applyStimulus(3, 10'h300, 10'h310, -1, 1'b0, 1'b0);
        checkOutput("pin_timeout_n3", 32'(err_cyc - run_cyc), 32'd14);

        $display("[TB] address wrap, N=4");
        applyStimulus(4, 10'h3FE, 10'h050, 1, 1'b0, 1'b1);
        checkOutput("pin_wrap_a0", 32'(arr_a[0]), 32'h1CF2);
        checkOutput("pin_wrap_a1", 32'(arr_a[1]), 32'h1CF9);
        checkOutput("pin_wrap_a2", 32'(arr_a[2]), 32'h0100);
        checkOutput("pin_wrap_a3", 32'(arr_a[3]), 32'h0107);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
